// File: rtl/kbd_scancode_fifo.sv
// Scancode FIFO behind port 60h with XT-style IRQ1 handshake on port 61h.
// Bytes are presented one at a time; a 61h bit7 pulse acknowledges each one.
module kbd_scancode_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic        iCodeValid,
    input  logic [7:0]  iCode,
    input  logic [19:0] iAddr,
    input  logic        iRd,
    input  logic        iWr,
    input  logic [7:0]  iData,
    output logic        oSel,
    output logic [7:0]  oData,
    output logic        oIrq,
    output logic        oOverflow
);

    typedef enum logic [1:0] {
        IDLE,
        PRES,
        ACK
    } state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    hold;
    logic          clr;

    logic sel60;
    logic sel61;
    logic ack_wr;
    logic pop;
    logic push;
    logic drop;
    logic leave_ack;
    logic unused;

    assign sel60  = (iAddr[11:0] == 12'h060);
    assign sel61  = (iAddr[11:0] == 12'h061);
    assign ack_wr = iWr && sel61 && iData[7];
    assign unused = ^{iAddr[19:12], iData[6:0]};

    assign pop  = (state == IDLE) && (count != '0) && !clr;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = iCodeValid && ((count != FULL) || pop);
    assign drop = iCodeValid && !push;

    always_comb begin
        state_nxt = state;
        leave_ack = 1'b0;
        unique case (state)
            IDLE: begin
                if (pop) state_nxt = PRES;
            end
            PRES: begin
                if (ack_wr) state_nxt = ACK;
            end
            ACK: begin
                if (!clr) begin
                    state_nxt = IDLE;
                    leave_ack = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (push) mem[wr_ptr] <= iCode;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold      <= 8'h00;
            clr       <= 1'b0;
            oSel      <= 1'b0;
            oData     <= 8'h00;
            oIrq      <= 1'b0;
            oOverflow <= 1'b0;
        end else begin
            state <= state_nxt;
            oIrq  <= (state_nxt == PRES);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (iWr && sel61) clr <= iData[7];
            if (drop) oOverflow <= 1'b1;
            else if (leave_ack) oOverflow <= 1'b0;
            oSel <= iRd && sel60;
            if (iRd && sel60) oData <= hold;
        end
    end

endmodule
